// File: rtl/score_pkg.sv
// =============================================================================
// score_pkg : shared types and constants for the score display/convert path.
// Rev 1.0
// =============================================================================
`default_nettype none

package score_pkg;

    localparam int BCD_W     = 4;
    localparam int DIGIT_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } score_state_t;

    // Elaboration-time 10^n, used to size-check the binary result width.
    function automatic longint unsigned pow10(input int n);
        longint unsigned v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mac10.sv
// =============================================================================
// bcd_mac10 : combinational acc*10 + digit via shift-add; clamps and flags
//             digits above 9 when SCORE_DIGIT_CHECK_EN is defined.
// Rev 1.0
// =============================================================================
`default_nettype none

module bcd_mac10
    import score_pkg::*;
#(
    parameter int OUT_W = 10
) (
    input  logic [OUT_W-1:0] i_acc,
    input  logic [BCD_W-1:0] i_digit,
    output logic [OUT_W-1:0] o_acc,
    output logic             o_err
);

    localparam int c_EXT_W = OUT_W + 4;

    logic [c_EXT_W-1:0] w_acc_ext;
    logic [BCD_W-1:0]   w_digit;

    assign w_acc_ext = {4'b0000, i_acc};

`ifdef SCORE_DIGIT_CHECK_EN
    assign o_err   = (i_digit > BCD_W'(DIGIT_MAX));
    assign w_digit = o_err ? BCD_W'(DIGIT_MAX) : i_digit;
`else
    assign o_err   = 1'b0;
    assign w_digit = i_digit;
`endif

    // Result wraps modulo 2^OUT_W.
    assign o_acc = OUT_W'((w_acc_ext << 3) + (w_acc_ext << 1) + c_EXT_W'(w_digit));

endmodule

`default_nettype wire

// File: rtl/score_bcd_to_bin.sv
// =============================================================================
// score_bcd_to_bin : iterative packed-BCD to binary score converter, one digit
//                    per clock MSD first. Optional macro: SCORE_DIGIT_CHECK_EN.
// Rev 1.0
// =============================================================================
`default_nettype none

module score_bcd_to_bin
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int OUT_W      = 10
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0] in_digits,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_score,
    output logic                        out_err
);

    localparam int                 c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    generate
        if ((64'd1 << OUT_W) < pow10(NUM_DIGITS)) begin : g_width_check
            $error("score_bcd_to_bin: OUT_W too narrow for NUM_DIGITS");
        end
    endgenerate

    score_state_t              r_state;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_err;
    logic [OUT_W-1:0]          r_acc;
    logic [c_IDX_W-1:0]        r_idx;
    logic [BCD_W*NUM_DIGITS-1:0] r_digits;

    logic [BCD_W-1:0]          w_digit;
    logic [OUT_W-1:0]          w_acc_next;
    logic                      w_digit_err;

    assign w_digit = r_digits[r_idx*BCD_W +: BCD_W];

    bcd_mac10 #(
        .OUT_W (OUT_W)
    ) u_mac (
        .i_acc   (r_acc),
        .i_digit (w_digit),
        .o_acc   (w_acc_next),
        .o_err   (w_digit_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_digits    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready rises on the first edge after reset release.
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_digits   <= in_digits;
                        r_acc      <= '0;
                        r_idx      <= c_IDX_LAST;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_acc_next;
                    r_err <= r_err | w_digit_err;
                    if (r_idx == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx - c_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_score = r_acc;
    assign out_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_score_bcd_to_bin.sv
// =============================================================================
// tb_score_bcd_to_bin : randomized self-checking bench with a decimal-weight
//                       reference model; also exercises a 4-digit instance.
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_score_bcd_to_bin;

`ifdef SCORE_DIGIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_digits = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_score;
    logic        out_err;

    logic        d4_in_valid = 1'b0;
    logic        d4_in_ready;
    logic [15:0] d4_in_digits = '0;
    logic        d4_out_valid;
    logic        d4_out_ready = 1'b0;
    logic [13:0] d4_out_score;
    logic        d4_out_err;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    score_bcd_to_bin #(.NUM_DIGITS(3), .OUT_W(10)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digits (in_digits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_err   (out_err)
    );

    score_bcd_to_bin #(.NUM_DIGITS(4), .OUT_W(14)) dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .in_digits (d4_in_digits),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready),
        .out_score (d4_out_score),
        .out_err   (d4_out_err)
    );

    // Reference: value = sum(digit_i * 10^i) mod 2^ow, with optional clamp to 9.
    function automatic void model(input logic [15:0] d, input int nd, input int ow,
                                  output longint unsigned v, output bit e);
        longint unsigned scale;
        scale = 1;
        v = 0;
        e = 1'b0;
        for (int i = 0; i < nd; i++) begin
            int dig;
            dig = int'(d[4*i +: 4]);
            if (CHK && dig > 9) begin
                dig = 9;
                e = 1'b1;
            end
            v = v + longint'(dig) * scale;
            scale = scale * 10;
        end
        v = v % (64'd1 << ow);
    endfunction

    task automatic send(input logic [11:0] d, output int edge_no, output bit ok);
        ok = 1'b0;
        edge_no = -1;
        in_valid = 1'b1;
        in_digits = d;
        for (int t = 0; t < 30; t++) begin
            if (in_ready) begin
                edge_no = cyc + 1;
                @(negedge clk);
                in_valid = 1'b0;
                in_digits = 12'($urandom);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rise(output int rise);
        rise = -1;
        for (int t = 0; t < 30; t++) begin
            if (out_valid) begin
                rise = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic recv(output logic [9:0] s, output logic e, output bit ok);
        ok = 1'b0;
        s = 'x;
        e = 1'bx;
        for (int t = 0; t < 60; t++) begin
            if (out_valid && out_ready) begin
                s = out_score;
                e = out_err;
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_score, out_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b score=%0d err=%b, expected all 0",
                     in_ready, out_valid, out_score, out_err);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int k, rise;
        bit ok;
        logic [9:0] s;
        logic e;
        out_ready = 1'b1;
        send(12'h999, k, ok);
        wait_rise(rise);
        n_checks++;
        if (!ok || rise < 0 || rise - k != 3) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, expected 3", rise - k);
        end
        recv(s, e, ok);
        n_checks++;
        if (!ok || s !== 10'd999) begin
            n_fail++;
            $display("FAIL basic_score: got %0d, expected 999", s);
        end
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: got %b, expected 0", e);
        end
    endtask

    task automatic test_back_to_back();
        int acc_e[2];
        logic [9:0] res[2];
        int n_acc, n_res;
        bit chg;
        acc_e = '{-1, -1};
        n_acc = 0;
        n_res = 0;
        chg = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_digits = 12'h042;
        for (int t = 0; t < 40 && n_res < 2; t++) begin
            if (chg) begin
                chg = 1'b0;
                if (n_acc == 1) in_digits = 12'h100;
                else in_valid = 1'b0;
            end
            if (in_valid && in_ready && n_acc < 2) begin
                acc_e[n_acc] = cyc + 1;
                n_acc++;
                chg = 1'b1;
            end
            if (out_valid && out_ready) begin
                res[n_res] = out_score;
                n_res++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc != 2 || n_res != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d accepts %0d results, expected 2 and 2", n_acc, n_res);
        end else begin
            n_checks++;
            if (acc_e[1] - acc_e[0] != 5) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles, expected 5", acc_e[1] - acc_e[0]);
            end
            n_checks++;
            if (res[0] !== 10'd42 || res[1] !== 10'd100) begin
                n_fail++;
                $display("FAIL b2b_results: got %0d,%0d expected 42,100", res[0], res[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int k, rise;
        bit ok;
        out_ready = 1'b0;
        send(12'h507, k, ok);
        wait_rise(rise);
        n_checks++;
        if (!ok || rise < 0) begin
            n_fail++;
            $display("FAIL bp_timeout: got no out_valid, expected one");
        end
        in_valid = 1'b1;
        in_digits = 12'h321;
        for (int t = 0; t < 10; t++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_score !== 10'd507 || in_ready !== 1'b0 || out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got vld=%b score=%0d rdy=%b err=%b, expected 1 507 0 0",
                         out_valid, out_score, in_ready, out_err);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_digit_check();
        int k;
        bit ok;
        logic [9:0] s;
        logic e;
        out_ready = 1'b1;
        send(12'h1A3, k, ok);
        recv(s, e, ok);
        n_checks++;
        if (!ok || s !== (CHK ? 10'd193 : 10'd203)) begin
            n_fail++;
            $display("FAIL digit_check_score: got %0d, expected %0d", s, CHK ? 193 : 203);
        end
        n_checks++;
        if (e !== CHK) begin
            n_fail++;
            $display("FAIL digit_check_err: got %b, expected %b", e, CHK);
        end
    endtask

    task automatic test_reset_mid_conv();
        int k;
        bit ok, seen;
        logic [9:0] s;
        logic e;
        out_ready = 1'b1;
        send(12'h123, k, ok);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got rdy=%b vld=%b, expected 0 0", in_ready, out_valid);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_discard: got out_valid=1, expected 0");
        end
        send(12'h001, k, ok);
        recv(s, e, ok);
        n_checks++;
        if (!ok || s !== 10'd1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_next: got %0d err=%b, expected 1 err=0", s, e);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [11:0] d;
            longint unsigned v;
            bit e_exp, ok;
            int k, rise;
            logic [9:0] s;
            logic e;
            for (int i = 0; i < 3; i++) begin
                d[4*i +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            end
            model({4'h0, d}, 3, 10, v, e_exp);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d, k, ok);
            wait_rise(rise);
            n_checks++;
            if (!ok || rise < 0 || rise - k != 3) begin
                n_fail++;
                $display("FAIL rand_latency: digits=%h got %0d edges, expected 3", d, rise - k);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready = 1'b1;
            recv(s, e, ok);
            out_ready = 1'b0;
            n_checks++;
            if (!ok || s !== v[9:0]) begin
                n_fail++;
                $display("FAIL rand_score: digits=%h got %0d, expected %0d", d, s, v[9:0]);
            end
            n_checks++;
            if (e !== e_exp) begin
                n_fail++;
                $display("FAIL rand_err: digits=%h got %b, expected %b", d, e, e_exp);
            end
        end
    endtask

    task automatic test_wide();
        d4_out_ready = 1'b1;
        for (int it = 0; it < 5; it++) begin
            logic [15:0] d;
            longint unsigned v;
            bit e_exp;
            int k4, rise;
            k4 = -1;
            rise = -1;
            if (it == 0) d = 16'h9999;
            else for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
            model(d, 4, 14, v, e_exp);
            d4_in_valid = 1'b1;
            d4_in_digits = d;
            for (int t = 0; t < 20; t++) begin
                if (d4_in_ready) begin
                    k4 = cyc + 1;
                    @(negedge clk);
                    break;
                end
                @(negedge clk);
            end
            d4_in_valid = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (d4_out_valid) begin
                    rise = cyc;
                    break;
                end
                @(negedge clk);
            end
            n_checks++;
            if (k4 < 0 || rise < 0 || rise - k4 != 4) begin
                n_fail++;
                $display("FAIL wide_latency: got %0d edges, expected 4", rise - k4);
            end
            n_checks++;
            if (d4_out_score !== v[13:0] || d4_out_err !== e_exp) begin
                n_fail++;
                $display("FAIL wide_score: digits=%h got %0d err=%b, expected %0d err=%b",
                         d, d4_out_score, d4_out_err, v[13:0], e_exp);
            end
            @(negedge clk);
        end
        d4_out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_digit_check();
        test_reset_mid_conv();
        test_random();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_bcd_to_bin.md
# score_bcd_to_bin

Sequential decimal-to-binary converter for the score path: it accepts a packed BCD score (hundreds/tens/ones by default) over a valid/ready handshake and returns the equivalent unsigned binary score over a second valid/ready handshake. It is the inverse of the binary-to-digit split that feeds the score display. It is used wherever a decimal score has to be turned back into a number for compare and update logic, such as a stored or entered high score. Conversion is iterative, one digit per clock, most-significant digit first.

## Interface
- `NUM_DIGITS`, 3: number of BCD digits accepted.
- `OUT_W`, 10: binary result width. Elaboration fails unless 2^OUT_W >= 10^NUM_DIGITS.
- `clk`  in  1: single clock, rising-edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_digits` holds a score to convert.
- `in_ready`  out  1: block can accept a score.
- `in_digits`  in  4*NUM_DIGITS: packed BCD. Digit i sits at [4i+3:4i]; digit 0 is the ones digit.
- `out_valid`  out  1: `out_score` and `out_err` are valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_score`  out  OUT_W: binary value of the captured digits.
- `out_err`  out  1: a captured digit was greater than 9. Only meaningful with `SCORE_DIGIT_CHECK_EN`.

## Operation
- States: IDLE, CONV, DONE.
- IDLE
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`&&`in_ready`: capture `in_digits` into a holding register, clear `acc` to 0, set `idx`=NUM_DIGITS-1 and clear the error flag, then go to CONV.
- CONV
  - `in_ready`=0.
  - Each cycle: acc <= (acc*10 + digit[idx]) truncated to OUT_W. The ×10 is formed as (acc<<3)+(acc<<1) in OUT_W+4 bits; no multiplier.
  - When `idx`==0, that cycle's update is the last one; go to DONE. Otherwise decrement `idx`.
- DONE
  - `out_valid`=1. `out_score`=acc and `out_err`=flag, both held stable until accepted.
  - On `out_ready`, go to IDLE.
- One conversion in flight; no pipelining. `in_ready` is low in CONV and DONE, and `in_valid` is ignored there.
- Captured digits are used, so `in_digits` may change after the accept edge without effect.
- Reset (any time, including mid-CONV or mid-DONE) forces IDLE.
  - Reset values: `in_ready`=0 while `resetn` is low and 1 after release; `out_valid`=0, `out_score`=0, `out_err`=0.
  - `acc`, `idx` and the digit register are cleared.
  - An in-flight result is discarded and never presented.

## Timing
- Accept on edge k. CONV updates happen on edges k+1 … k+NUM_DIGITS. `out_valid` is high in the cycle after edge k+NUM_DIGITS (3 edges by default).
- `out_valid`&&`out_ready` on edge m: IDLE from edge m. `in_ready` is high in the following cycle, so the next accept is possible at edge m+1 at the earliest.
- Minimum accept-to-accept spacing is NUM_DIGITS+2 cycles when `out_ready` is held high.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- `SCORE_DIGIT_CHECK_EN` defined:
  - Each digit is checked as it is consumed in CONV.
  - A digit > 9 sets the sticky error flag and is replaced by 9 in the accumulation.
  - `out_err` reflects the flag in DONE.
  - Example: digits 1,A,3 give `out_score`=193 and `out_err`=1.
- Not defined:
  - Digits are used raw: value = Σ digit·10^i mod 2^OUT_W.
  - The checking logic is absent and `out_err` is tied to 0.

## Structure
- Package `score_pkg` holds:
  - the state enum (IDLE/CONV/DONE);
  - `BCD_W`=4;
  - `DIGIT_MAX`=9.
  - The display-side score logic shares this package.
- One natural sub-module, `bcd_mac10`: combinational acc*10+digit (shift-add). It also contains the clamp and error detect under `SCORE_DIGIT_CHECK_EN`. The top holds the FSM, `idx` counter, holding register and handshakes.

## Test plan
- Digits 9,9,9 with `out_ready`=1 → `out_valid` rises 3 cycles after accept; `out_score`=999 (0x3E7), `out_err`=0.
- Digits 0,4,2 and 1,0,0 back-to-back with `in_valid` held high → results 42 then 100; second accept occurs exactly 5 cycles after the first.
- Digits 5,0,7 with `out_ready`=0 for 10 cycles → `out_score`=507 held stable and `in_ready`=0 throughout; accepted on `out_ready`, then `in_ready`=1 the next cycle.
- `resetn` pulsed low during the second CONV cycle → `out_valid` never asserts for that score. A new score 0,0,1 after release → 1.
- `SCORE_DIGIT_CHECK_EN` defined: digits 1,A,3 → `out_score`=193, `out_err`=1. Macro undefined: the same digits → 1·100+10·10+3=203, `out_err`=0.
- `NUM_DIGITS`=4, `OUT_W`=14: digits 9,9,9,9 → 9999 after 4 cycles.
